// File: rtl/waveform_meter.sv
// waveform_meter: tracks a signed sample stream, detects peaks and valleys with hysteresis and
// reports the peak-to-peak period in clocks plus the last peak/valley amplitudes.
// Optional feature: define WAVEFORM_METER_AMPL_EN to add ampl_o (peak minus last valley).
module waveform_meter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PER_WIDTH  = 24,
  parameter int unsigned HYST       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  input  logic                         clear_i,
  output logic        [PER_WIDTH-1:0]  period_o,
  output logic signed [DATA_WIDTH-1:0] peak_o,
  output logic signed [DATA_WIDTH-1:0] valley_o,
  output logic                         meas_valid_o,
  output logic                         ovf_o
`ifdef WAVEFORM_METER_AMPL_EN
  ,
  output logic        [DATA_WIDTH:0]   ampl_o
`endif
);

  typedef enum logic [1:0] {StAcquire, StRising, StFalling} state_e;

  // One extra bit keeps sample/extremum differences exact at full scale.
  localparam logic signed [DATA_WIDTH:0]  HystS    = (DATA_WIDTH + 1)'(HYST);
  localparam logic signed [DATA_WIDTH:0]  Zero     = '0;
  localparam logic        [PER_WIDTH-1:0] CntMax   = '1;
  localparam logic        [PER_WIDTH-1:0] CntSatM1 = CntMax - 1'b1;

  state_e                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] ext_q, ext_d;
  logic signed [DATA_WIDTH-1:0] peak_q, peak_d;
  logic signed [DATA_WIDTH-1:0] valley_q, valley_d;
  logic        [PER_WIDTH-1:0]  cnt_q, cnt_d;
  logic        [PER_WIDTH-1:0]  period_q, period_d;
  logic                         seen_q, seen_d;
  logic                         have_peak_q, have_peak_d;
  logic                         meas_valid_q, meas_valid_d;
  logic                         ovf_q, ovf_d;
`ifdef WAVEFORM_METER_AMPL_EN
  logic        [DATA_WIDTH:0]   ampl_q, ampl_d;
`endif

  logic signed [DATA_WIDTH:0]   samp_x, ext_x, valley_x;
  logic signed [DATA_WIDTH:0]   rise_diff, fall_diff;
  logic                         cnt_full, sat_hit, peak_ev;

  assign samp_x    = {sample_i[DATA_WIDTH-1], sample_i};
  assign ext_x     = {ext_q[DATA_WIDTH-1], ext_q};
  assign valley_x  = {valley_q[DATA_WIDTH-1], valley_q};
  assign rise_diff = samp_x - ext_x;  // sample above extremum
  assign fall_diff = ext_x - samp_x;  // sample below extremum
  assign cnt_full  = (cnt_q == CntMax);
  // Fires once, on the clock where the counter reaches all-ones.
  assign sat_hit   = (cnt_q == CntSatM1);

  // Next-state: extremum tracking FSM, peak/valley events and period counter.
  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    peak_d       = peak_q;
    valley_d     = valley_q;
    period_d     = period_q;
    seen_d       = seen_q;
    have_peak_d  = have_peak_q;
    ovf_d        = ovf_q;
    meas_valid_d = 1'b0;
    peak_ev      = 1'b0;
    cnt_d        = cnt_full ? cnt_q : cnt_q + 1'b1;
`ifdef WAVEFORM_METER_AMPL_EN
    ampl_d       = ampl_q;
`endif

    if (sample_valid_i) begin
      unique case (state_q)
        StAcquire: begin
          if (!seen_q) begin
            seen_d = 1'b1;
            ext_d  = sample_i;
          end else if (rise_diff > HystS) begin
            state_d = StRising;
            ext_d   = sample_i;
          end else if (fall_diff > HystS) begin
            state_d = StFalling;
            ext_d   = sample_i;
          end
        end
        StRising: begin
          if (rise_diff > Zero) begin
            ext_d = sample_i;
          end else if (fall_diff > HystS) begin
            peak_ev = 1'b1;
            state_d = StFalling;
            ext_d   = sample_i;
          end
        end
        StFalling: begin
          if (fall_diff > Zero) begin
            ext_d = sample_i;
          end else if (rise_diff > HystS) begin
            valley_d = ext_q;
            state_d  = StRising;
            ext_d    = sample_i;
          end
        end
        default: state_d = StAcquire;
      endcase
    end

    if (peak_ev) begin
      peak_d      = ext_q;
      cnt_d       = '0;
      have_peak_d = 1'b1;
      // The very first peak only starts the period measurement.
      if (have_peak_q) begin
        period_d     = cnt_q + 1'b1;
        meas_valid_d = 1'b1;
        ovf_d        = 1'b0;
`ifdef WAVEFORM_METER_AMPL_EN
        ampl_d       = ext_x - valley_x;
`endif
      end
    end else if (sat_hit) begin
      // No peak within the counter range: restart acquisition, keep last results.
      ovf_d       = 1'b1;
      state_d     = StAcquire;
      seen_d      = 1'b0;
      have_peak_d = 1'b0;
      valley_d    = valley_q;
    end
  end

  // State register with synchronous reset; clear_i behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q      <= StAcquire;
      ext_q        <= '0;
      peak_q       <= '0;
      valley_q     <= '0;
      cnt_q        <= '0;
      period_q     <= '0;
      seen_q       <= 1'b0;
      have_peak_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef WAVEFORM_METER_AMPL_EN
      ampl_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      peak_q       <= peak_d;
      valley_q     <= valley_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      seen_q       <= seen_d;
      have_peak_q  <= have_peak_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
`ifdef WAVEFORM_METER_AMPL_EN
      ampl_q       <= ampl_d;
`endif
    end
  end

  assign period_o     = period_q;
  assign peak_o       = peak_q;
  assign valley_o     = valley_q;
  assign meas_valid_o = meas_valid_q;
  assign ovf_o        = ovf_q;
`ifdef WAVEFORM_METER_AMPL_EN
  assign ampl_o       = ampl_q;
`endif

endmodule

// File: tb/tb_waveform_meter.sv
// Self-checking bench for waveform_meter: three instances (default, 8-bit period counter,
// hysteresis 20) share one stimulus stream and are compared every cycle to a reference model.
module tb_waveform_meter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               valid = 1'b0;
  logic signed [15:0] sample = '0;

  logic        [23:0] per0, per2;
  logic        [7:0]  per1;
  logic signed [15:0] pk0, pk1, pk2, vl0, vl1, vl2;
  logic               mv0, mv1, mv2, ov0, ov1, ov2;
`ifdef WAVEFORM_METER_AMPL_EN
  logic        [16:0] am0, am1, am2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  waveform_meter dut0 (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(per0), .peak_o(pk0), .valley_o(vl0), .meas_valid_o(mv0), .ovf_o(ov0)
`ifdef WAVEFORM_METER_AMPL_EN
    , .ampl_o(am0)
`endif
  );

  waveform_meter #(.PER_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(per1), .peak_o(pk1), .valley_o(vl1), .meas_valid_o(mv1), .ovf_o(ov1)
`ifdef WAVEFORM_METER_AMPL_EN
    , .ampl_o(am1)
`endif
  );

  waveform_meter #(.HYST(20)) dut2 (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(per2), .peak_o(pk2), .valley_o(vl2), .meas_valid_o(mv2), .ovf_o(ov2)
`ifdef WAVEFORM_METER_AMPL_EN
    , .ampl_o(am2)
`endif
  );

  // Reference model: direction is +1 rising, -1 falling, 0 still acquiring.
  typedef struct {
    int     dir;
    bit     seen;
    int     ext;
    longint cnt;
    bit     have;
    longint period;
    int     peak;
    int     valley;
    bit     mv;
    bit     ovf;
    longint ampl;
  } m_t;

  m_t m0, m1, m2;

  function automatic m_t model_reset();
    m_t z;
    z.dir = 0; z.seen = 0; z.ext = 0; z.cnt = 0; z.have = 0; z.period = 0;
    z.peak = 0; z.valley = 0; z.mv = 0; z.ovf = 0; z.ampl = 0;
    return z;
  endfunction

  function automatic m_t model_step(m_t m, int s, bit v, bit clr, int hyst, longint cmax);
    m_t n;
    bit pk;
    if (clr) return model_reset();
    n    = m;
    pk   = 0;
    n.mv = 0;
    n.cnt = (m.cnt == cmax) ? cmax : m.cnt + 1;
    if (v) begin
      if (m.dir == 0) begin
        if (!m.seen) begin n.seen = 1; n.ext = s; end
        else if (s - m.ext > hyst) begin n.dir = 1;  n.ext = s; end
        else if (m.ext - s > hyst) begin n.dir = -1; n.ext = s; end
      end else if (m.dir == 1) begin
        if (s > m.ext) n.ext = s;
        else if (m.ext - s > hyst) begin pk = 1; n.dir = -1; n.ext = s; end
      end else begin
        if (s < m.ext) n.ext = s;
        else if (s - m.ext > hyst) begin n.valley = m.ext; n.dir = 1; n.ext = s; end
      end
    end
    if (pk) begin
      n.peak = m.ext;
      n.cnt  = 0;
      if (m.have) begin
        n.period = m.cnt + 1;
        n.mv     = 1;
        n.ovf    = 0;
        n.ampl   = longint'(m.ext - m.valley) & 64'h1FFFF;
      end
      n.have = 1;
    end else if (n.cnt == cmax && m.cnt != cmax) begin
      n.ovf    = 1;
      n.dir    = 0;
      n.seen   = 0;
      n.have   = 0;
      n.valley = m.valley;
    end
    return n;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input longint per, input int pk, input int vl,
                           input bit mv, input bit ov, input longint am, input m_t m);
    check({tag, ".period"}, per, m.period);
    check({tag, ".peak"},   pk,  m.peak);
    check({tag, ".valley"}, vl,  m.valley);
    check({tag, ".mv"},     mv,  m.mv);
    check({tag, ".ovf"},    ov,  m.ovf);
`ifdef WAVEFORM_METER_AMPL_EN
    check({tag, ".ampl"},   am,  m.ampl);
`endif
  endtask

  // One clock: drive inputs, advance DUTs and models, compare every output.
  task automatic step(input int s, input bit v, input bit clr, input bit r);
    longint a0, a1, a2;
    sample = 16'(s);
    valid  = v;
    clear  = clr;
    rst    = r;
    @(posedge clk);
    #1;
    m0 = model_step(m0, s, v, clr | r, 0,  64'hFF_FFFF);
    m1 = model_step(m1, s, v, clr | r, 0,  64'hFF);
    m2 = model_step(m2, s, v, clr | r, 20, 64'hFF_FFFF);
    a0 = 0; a1 = 0; a2 = 0;
`ifdef WAVEFORM_METER_AMPL_EN
    a0 = am0; a1 = am1; a2 = am2;
`endif
    check_dut("d0", per0, pk0, vl0, mv0, ov0, a0, m0);
    check_dut("d1", per1, pk1, vl1, mv1, ov1, a1, m1);
    check_dut("d2", per2, pk2, vl2, mv2, ov2, a2, m2);
  endtask

  // Triangle -100..+100 in steps of 10, 40 samples per period; optional +-5 dither.
  function automatic int tri_wave(int i, bit dith);
    int p, t;
    p = i % 40;
    t = (p < 20) ? -100 + 10 * p : 100 - 10 * (p - 20);
    if (dith) t += (i % 2) ? 5 : -5;
    return t;
  endfunction

  typedef struct {
    int kind;  // 0 triangle, 1 rectangle (a high, b low), 2 dithered triangle
    int a;
    int b;
    int nsamp;
    int exp_period;
    int exp_peak;
    int exp_valley;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first_ovf, found, prev, walk, hi, kind, len, s;
    vecs[0] = '{0, 0,  0,  200, 40, 100,  -100};
    vecs[1] = '{1, 30, 30, 240, 60, 1000, -1000};
    vecs[2] = '{1, 15, 45, 240, 60, 1000, -1000};
    vecs[3] = '{2, 0,  0,  200, 40, 95,   -105};

    m0 = model_reset(); m1 = model_reset(); m2 = model_reset();

    // Reset with random samples, then constant input: no pulse.
    step(int'($urandom_range(0, 65535)) - 32768, 1, 0, 1);
    step(int'($urandom_range(0, 65535)) - 32768, 1, 0, 1);
    check("rst.period", per0, 0);
    check("rst.peak",   pk0,  0);
    check("rst.valley", vl0,  0);
    check("rst.mv",     mv0,  0);
    check("rst.ovf",    ov0,  0);
    for (int i = 0; i < 3; i++) begin
      step(123, 1, 0, 0);
      check("rst.nopulse", mv0, 0);
    end

    // Table-driven steady-state waveforms.
    for (int v = 0; v < 4; v++) begin
      step(0, 1, 1, 0);
      pulses = 0;
      for (int i = 0; i < vecs[v].nsamp; i++) begin
        if (vecs[v].kind == 1) s = (i % (vecs[v].a + vecs[v].b) < vecs[v].a) ? 1000 : -1000;
        else s = tri_wave(i, vecs[v].kind == 2);
        step(s, 1, 0, 0);
        if (mv0) pulses++;
      end
      check("tbl.period0", per0, vecs[v].exp_period);
      check("tbl.period1", per1, vecs[v].exp_period);
      check("tbl.period2", per2, vecs[v].exp_period);
      check("tbl.peak0",   pk0,  vecs[v].exp_peak);
      check("tbl.valley0", vl0,  vecs[v].exp_valley);
      check("tbl.pulses",  pulses >= 2, 1);
    end

    // Constant input saturates the 8-bit counter; triangle then clears ovf with a pulse.
    step(0, 1, 0, 1);
    first_ovf = -1;
    pulses = 0;
    for (int j = 1; j <= 300; j++) begin
      step(500, 1, 0, 0);
      if (ov1 && first_ovf < 0) first_ovf = j;
      if (mv1) pulses++;
    end
    check("ovf.cycle",   first_ovf, 255);
    check("ovf.nopulse", pulses, 0);
    check("ovf.wide",    ov0, 0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      prev = ov1;
      step(tri_wave(i, 0), 1, 0, 0);
      if (mv1) begin
        found = 1;
        check("ovf.held",   prev, 1);
        check("ovf.clr",    ov1, 0);
        check("ovf.period", per1, 40);
      end
    end
    check("ovf.pulse_seen", found, 1);

    // Clear coincident with a peak-triggering sample.
    step(0, 1, 1, 0);
    for (int i = 0; i <= 100; i++) step(tri_wave(i, 0), 1, 0, 0);
    step(tri_wave(101, 0), 1, 1, 0);
    check("clr.period", per0, 0);
    check("clr.peak",   pk0,  0);
    check("clr.valley", vl0,  0);
    check("clr.mv",     mv0,  0);
    found = -1;
    for (int i = 102; i < 300 && found < 0; i++) begin
      step(tri_wave(i, 0), 1, 0, 0);
      if (mv0) begin
        found = i;
        check("clr.period_after", per0, 40);
      end
    end
    check("clr.pulse_delay", found - 101, 80);

    // Randomised segments: full-scale square, random walk, white noise; gaps and clears.
    walk = 0;
    hi = 0;
    for (int seg = 0; seg < 40; seg++) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(20, 90));
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: begin
            if ($urandom_range(0, 9) == 0) hi = 1 - hi;
            s = hi ? 32767 : -32768;
          end
          1: begin
            walk += int'($urandom_range(0, 60)) - 30;
            if (walk > 32767) walk = 32767;
            if (walk < -32768) walk = -32768;
            s = walk;
          end
          default: s = int'($urandom_range(0, 65535)) - 32768;
        endcase
        step(s, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_meter.md
Name: waveform_meter

Overview:
- Downstream consumer of the waveform generator output.
- Tracks the signed sample stream, detects peaks and valleys with programmable hysteresis, and reports peak-to-peak period in clock cycles plus the last peak/valley amplitudes.
- Gives the hardware self-check for waveform generator frequency settings; output feeds the status/readback logic.

Parameters:
- DATA_WIDTH, 16, sample width; matches the generator's wave output width.
- PER_WIDTH, 24, period counter width.
- HYST, 0, unsigned reversal threshold in LSBs; a direction change counts only when the sample moves more than HYST away from the tracked extremum.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sample_i  in  DATA_WIDTH  signed sample from generator
- sample_valid_i  in  1  sample_i qualifier; tie high for every-cycle sampling
- clear_i  in  1  synchronous soft clear; same effect as rst
- period_o  out  PER_WIDTH  clocks between the last two detected peaks
- peak_o  out  DATA_WIDTH  signed value of last detected peak
- valley_o  out  DATA_WIDTH  signed value of last detected valley
- meas_valid_o  out  1  one-cycle pulse when period_o/peak_o are updated
- ovf_o  out  1  sticky; period counter saturated with no peak

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset or clear_i: all outputs 0; FSM state ACQUIRE; ext = 0; cnt = 0; have_peak = 0.
- clear_i has priority over a simultaneous sample, which is ignored.
- cnt increments every clk regardless of sample_valid_i. It saturates at 2^PER_WIDTH-1.
- FSM states ACQUIRE, RISING, FALLING. Only cycles with sample_valid_i = 1 are evaluated.
- ACQUIRE, first valid sample: ext = sample.
- ACQUIRE, later samples: sample > ext+HYST -> RISING with ext = sample. sample < ext-HYST -> FALLING with ext = sample. Otherwise stay.
- RISING: sample > ext -> ext = sample. (ext - sample) > HYST -> peak event, then FALLING with ext = sample. Otherwise hold; equal samples hold.
- FALLING: sample < ext -> ext = sample. (sample - ext) > HYST -> valley event: valley_o = ext, then RISING with ext = sample.
- Peak event, first one (have_peak = 0): peak_o = ext; cnt = 0; have_peak = 1; no pulse.
- Peak event, subsequent ones: period_o = cnt+1 (clocks since the previous peak event); peak_o = ext; cnt = 0; meas_valid_o = 1 next cycle; ovf_o cleared.
- Latency: outputs register on the edge following the triggering sample; pulse is high exactly one cycle.
- Comparisons use DATA_WIDTH+1 signed arithmetic; no wrap at ±full scale.
- Saturation: when cnt reaches all-ones with no peak, ovf_o = 1 (sticky). FSM returns to ACQUIRE; have_peak = 0; period_o/peak_o/valley_o hold. This covers halted or constant input.
- ovf_o clears on the next meas_valid_o, clear_i or rst.
- Rectangular input: the flat top holds RISING; the drop triggers the peak event. Period equals the rectangle period for any duty cycle.
- Reset mid-measurement discards partial period; no pulse is emitted.

Optional Feature:
- Macro WAVEFORM_METER_AMPL_EN.
- Defined: adds output port ampl_o (DATA_WIDTH+1 unsigned) = peak_o - last valley_o. It is registered together with meas_valid_o; reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst high 2 cycles with random sample_i -> all outputs 0, no meas_valid_o for 3 cycles after release with constant input.
- Triangle, HYST = 0, valid every cycle, -100..+100 step 10 -> first pulse after second peak; period_o = 40, peak_o = 100, valley_o = -100 on every pulse. ampl_o = 200 with WAVEFORM_METER_AMPL_EN.
- Rectangle, +1000 for 30 cycles then -1000 for 30 cycles; repeat with 15/45 split -> period_o = 60 both cases, peak_o = 1000, valley_o = -1000.
- Constant 500, PER_WIDTH = 8 -> ovf_o = 1 at cycle 255, no pulse. Resume triangle -> ovf_o clears with first pulse after two new peaks.
- HYST = 20, triangle from scenario 2 with ±5 dither every other sample -> dither ignored, period_o = 40.
- clear_i asserted coincident with a peak-triggering sample -> no pulse, outputs 0. The next pulse arrives only after two fresh peaks, with correct period_o.
